// File: rtl/avg_ram_ctrl.sv
// Four-sample averaging controller: reads bytes from a FIFO into an external averager and writes each mean to RAM.
// Build option: define AVG_RAM_CTRL_WRAP_EN to wrap the RAM address instead of stopping when the RAM is full.
module avg_ram_ctrl #(
   parameter int ADDR_W = 11
) (
   input  logic              clk_2,
   input  logic              reset_n,
   input  logic              fifo_empty,
   input  logic [7:0]        fifo_data,
   output logic              fifo_rd,
   output logic [7:0]        avg_data,
   output logic              zero_sel,
   output logic              reg_out,
   output logic              ram_wr_n,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_full
);

   typedef enum logic [2:0] {
      COLLECT = 3'd0,
      LAST    = 3'd1,
      DUMP    = 3'd2,
      WRITE   = 3'd3,
      CLEAR   = 3'd4,
      FULL    = 3'd5
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t              state_q, state_d;
   logic [2:0]          rd_cnt_q, rd_cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                full_q, full_d;
   logic                rd_valid_q;
   logic                reg_out_q;
   logic                zero_sel_q;
   logic                ram_wr_n_q;
   logic                rd_issue;

   // Gated by reset_n so no byte is consumed while reset is held.
   assign rd_issue = reset_n && (state_q == COLLECT) && !fifo_empty && (rd_cnt_q < 3'd4);

   always_comb begin
      state_d  = state_q;
      rd_cnt_d = rd_cnt_q;
      addr_d   = addr_q;
      full_d   = full_q;
      case (state_q)
         COLLECT: begin
            if (rd_issue) begin
               rd_cnt_d = rd_cnt_q + 3'd1;
               if (rd_cnt_q == 3'd3) begin
                  state_d = LAST;
               end
            end
         end
         LAST:  state_d = DUMP;
         DUMP:  state_d = WRITE;
         WRITE: state_d = CLEAR;
         CLEAR: begin
            rd_cnt_d = 3'd0;
`ifdef AVG_RAM_CTRL_WRAP_EN
            addr_d  = addr_q + 1'b1;
            state_d = COLLECT;
`else
            if (addr_q == LAST_ADDR) begin
               state_d = FULL;
               full_d  = 1'b1;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = COLLECT;
            end
`endif
         end
         FULL:    state_d = FULL;
         default: state_d = COLLECT;
      endcase
   end

   // Strobes are decoded from the next state so they are registered yet line up with the state.
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= COLLECT;
         rd_cnt_q   <= 3'd0;
         addr_q     <= '0;
         full_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         reg_out_q  <= 1'b0;
         zero_sel_q <= 1'b0;
         ram_wr_n_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         rd_cnt_q   <= rd_cnt_d;
         addr_q     <= addr_d;
         full_q     <= full_d;
         rd_valid_q <= rd_issue;
         reg_out_q  <= (state_d == DUMP);
         zero_sel_q <= (state_d == CLEAR);
         ram_wr_n_q <= (state_d != WRITE);
      end
   end

   assign fifo_rd  = rd_issue;
   assign avg_data = rd_valid_q ? fifo_data : 8'h00;
   assign reg_out  = reg_out_q;
   assign zero_sel = zero_sel_q;
   assign ram_wr_n = ram_wr_n_q;
   assign ram_addr = addr_q;
   assign ram_full = full_q;

endmodule

// File: tb/tb_avg_ram_ctrl.sv
// Bench for avg_ram_ctrl: FIFO and averager stand-ins, write scoreboard, directed groups with hand-computed means.
module tb_avg_ram_ctrl;

   localparam int ADDR_W = 2;

   logic              clk_2 = 1'b0;
   logic              reset_n;
   logic              fifo_empty;
   logic [7:0]        fifo_data = 8'h00;
   logic              fifo_rd;
   logic [7:0]        avg_data;
   logic              zero_sel;
   logic              reg_out;
   logic              ram_wr_n;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_full;

   avg_ram_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk_2      (clk_2),
      .reset_n    (reset_n),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd    (fifo_rd),
      .avg_data   (avg_data),
      .zero_sel   (zero_sel),
      .reg_out    (reg_out),
      .ram_wr_n   (ram_wr_n),
      .ram_addr   (ram_addr),
      .ram_full   (ram_full)
   );

   always #5 clk_2 = ~clk_2;

   // FIFO stand-in: pointer-based store, data appears the cycle after the read strobe.
   logic [7:0] fmem [0:63];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   logic       stall = 1'b0;

   assign fifo_empty = (rd_ptr == wr_ptr) || stall;

   always @(posedge clk_2) begin
      if (fifo_rd) begin
         fifo_data <= fmem[rd_ptr[5:0]];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   // Averager stand-in sharing reset_n: accumulate, clear on zero_sel, latch sum>>2 on reg_out.
   logic [9:0] acc;
   logic [7:0] ram_data;

   always @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         acc      <= 10'd0;
         ram_data <= 8'h00;
      end else begin
         if (zero_sel) acc <= 10'd0;
         else          acc <= acc + {2'b00, avg_data};
         if (reg_out)  ram_data <= acc[9:2];
      end
   end

   typedef struct {
      int addr;
      int data;
   } exp_t;

   exp_t exp_q [$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_byte(input int b);
      fmem[wr_ptr[5:0]] = b[7:0];
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic push_group(input int b0, input int b1, input int b2, input int b3,
                             input int addr, input int mean);
      exp_t e;
      push_byte(b0);
      push_byte(b1);
      push_byte(b2);
      push_byte(b3);
      e.addr = addr;
      e.data = mean;
      exp_q.push_back(e);
      $display("issue group %0d,%0d,%0d,%0d -> expect %0d @ addr %0d", b0, b1, b2, b3, mean, addr);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk_2);
      end
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s_timeout: got %0d pending writes required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_reads(input int target);
      for (int i = 0; i < 100; i++) begin
         if (rd_ptr >= target) break;
         @(posedge clk_2);
         #1;
      end
      chk("read_wait", rd_ptr, target);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_fifo_rd"},  int'(fifo_rd),  0);
      chk({tag, "_avg_data"}, int'(avg_data), 0);
      chk({tag, "_reg_out"},  int'(reg_out),  0);
      chk({tag, "_zero_sel"}, int'(zero_sel), 0);
      chk({tag, "_ram_wr_n"}, int'(ram_wr_n), 1);
      chk({tag, "_ram_addr"}, int'(ram_addr), 0);
      chk({tag, "_ram_full"}, int'(ram_full), 0);
   endtask

   task automatic pulse_reset();
      @(posedge clk_2);
      #1 reset_n = 1'b0;
      @(posedge clk_2);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      exp_t       e;
      logic [3:0] got;
      logic [3:0] want;
      int         base;

      reset_n = 1'b0;

      // Scoreboard monitor: every RAM write is matched against the oldest expected entry.
      fork
         forever begin
            @(negedge clk_2);
            if (reset_n) begin
               if (!ram_wr_n) begin
                  if (exp_q.size() == 0) begin
                     n_vec++;
                     n_err++;
                     $display("FAIL unexpected_write: got %0d @ addr %0d required no write", ram_data, ram_addr);
                  end else begin
                     e = exp_q.pop_front();
                     $display("write %0d @ addr %0d (expect %0d @ %0d)", ram_data, ram_addr, e.data, e.addr);
                     chk("wr_addr", int'(ram_addr), e.addr);
                     chk("wr_data", int'(ram_data), e.data);
                  end
               end
               if (reg_out || zero_sel || !ram_wr_n) begin
                  chk("strobe_onehot", int'(reg_out) + int'(zero_sel) + int'(!ram_wr_n), 1);
               end
            end
         end
      join_none

      // Group 10,20,30,40 queued during reset; check reset state and cycle-exact strobes.
      repeat (3) @(posedge clk_2);
      #1;
      push_group(10, 20, 30, 40, 0, 25);
      @(negedge clk_2);
      check_reset_outputs("rst0");
      @(posedge clk_2);
      #1 reset_n = 1'b1;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk_2);
         got  = {fifo_rd, reg_out, ~ram_wr_n, zero_sel};
         want = (k < 4) ? 4'b1000 : (k == 5) ? 4'b0100 : (k == 6) ? 4'b0010 : (k == 7) ? 4'b0001 : 4'b0000;
         chk($sformatf("t1_cycle%0d_rd_reg_wr_zero", k), int'(got), int'(want));
      end
      wait_drain("t1");

      // Saturated group then a small one at the next address.
      pulse_reset();
      push_group(255, 255, 255, 255, 0, 255);
      push_group(0, 1, 2, 3, 1, 1);
      wait_drain("t2");

      // Three-cycle FIFO gap after the second read.
      pulse_reset();
      base = rd_ptr;
      push_group(1, 2, 3, 6, 0, 3);
      wait_reads(base + 2);
      stall = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk_2);
         chk($sformatf("gap%0d_fifo_rd", j), int'(fifo_rd), 0);
         if (j > 0) chk($sformatf("gap%0d_avg_data", j), int'(avg_data), 0);
      end
      @(posedge clk_2);
      #1 stall = 1'b0;
      wait_drain("t3");

      // Reset mid-group at address 1 discards the partial sum.
      base = rd_ptr;
      push_byte(100);
      push_byte(100);
      wait_reads(base + 2);
      @(posedge clk_2);
      #1 reset_n = 1'b0;
      @(negedge clk_2);
      check_reset_outputs("rst_mid");
      @(posedge clk_2);
      #1 reset_n = 1'b1;
      push_group(4, 4, 4, 4, 0, 4);
      wait_drain("t4");

      // Five groups into a four-entry RAM.
      pulse_reset();
      for (int g = 0; g < 4; g++) begin
         push_group(8 * (g + 1), 8 * (g + 1), 8 * (g + 1), 8 * (g + 1), g, 8 * (g + 1));
      end
`ifdef AVG_RAM_CTRL_WRAP_EN
      push_group(40, 40, 40, 40, 0, 40);
      wait_drain("t5");
      repeat (20) @(negedge clk_2);
      chk("wrap_ram_full", int'(ram_full), 0);
      chk("wrap_fifo_left", wr_ptr - rd_ptr, 0);
`else
      for (int b = 0; b < 4; b++) push_byte(40);
      wait_drain("t5");
      repeat (20) @(negedge clk_2);
      chk("full_ram_full", int'(ram_full), 1);
      chk("full_fifo_rd", int'(fifo_rd), 0);
      chk("full_fifo_left", wr_ptr - rd_ptr, 4);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/avg_ram_ctrl.md
AVG_RAM_CTRL -- requirements
Module: avg_ram_ctrl

Interface
REQ-001 Parameter ADDR_W, default 11, sets the RAM address width (depth 2**ADDR_W).
REQ-002 clk_2  input  1  system clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 fifo_empty  input  1  upstream byte FIFO empty flag.
REQ-005 fifo_data  input  8  FIFO read data, valid the cycle after fifo_rd.
REQ-006 fifo_rd  output  1  FIFO read strobe, one byte per asserted cycle.
REQ-007 avg_data  output  8  byte presented to the averager data input.
REQ-008 zero_sel  output  1  averager accumulator clear.
REQ-009 reg_out  output  1  averager result-latch strobe (buffer>>2 into ram_data).
REQ-010 ram_wr_n  output  1  RAM write enable, active-low; RAM data comes from the averager ram_data.
REQ-011 ram_addr  output  ADDR_W  RAM write address.
REQ-012 ram_full  output  1  set when the RAM has been filled and writing has stopped.

Function
REQ-013 The FSM SHALL have states COLLECT, LAST, DUMP, WRITE, CLEAR and FULL; all outputs except fifo_rd and avg_data SHALL be Moore-decoded from the state.
REQ-014 In COLLECT: fifo_rd = !fifo_empty && rd_cnt<4 (combinational); rd_cnt (3 bits) SHALL increment on each issued read.
REQ-015 rd_valid SHALL be fifo_rd registered by one clk_2; avg_data = rd_valid ? fifo_data : 8'h00, so the averager adds exactly one byte per read and adds 0 on all other cycles.
REQ-016 COLLECT->LAST on the cycle the 4th read issues; LAST lasts 1 cycle, during which the 4th byte is accumulated.
REQ-017 LAST->DUMP (reg_out=1, 1 cycle)->WRITE (ram_wr_n=0, 1 cycle)->CLEAR (zero_sel=1, 1 cycle).
REQ-018 CLEAR->COLLECT with rd_cnt cleared and ram_addr incremented at that same edge.
REQ-019 reg_out, zero_sel and ram_wr_n=0 SHALL be mutually exclusive; zero_sel and reg_out SHALL be 0 in COLLECT and LAST.
REQ-020 ram_addr SHALL be stable from the start of DUMP to the end of WRITE.
REQ-021 Latency with a never-empty FIFO: reads in cycles 0-3, LAST 4, DUMP 5, WRITE 6, CLEAR 7, next read in cycle 8 (8 cycles per output byte).
REQ-022 fifo_empty asserted in COLLECT SHALL stall reads without changing rd_cnt; the partial sum is preserved.
REQ-023 fifo_rd SHALL be 0 in every state other than COLLECT.
REQ-024 Averaging is fixed at 4 samples; the maximum sum of 1020 fits the averager's 10-bit buffer, so there is no overflow handling.

Reset
REQ-025 On reset_n low: state=COLLECT, rd_cnt=0, rd_valid=0, ram_addr=0, ram_full=0, reg_out=0, zero_sel=0, ram_wr_n=1, and fifo_rd=0 while reset is held.
REQ-026 Reset mid-group SHALL discard the partial group; the averager shares reset_n, so its buffer is also cleared, and the next 4 reads form a fresh group at address 0.

Configuration
REQ-027 Macro AVG_RAM_CTRL_WRAP_EN defined: CLEAR at address 2**ADDR_W-1 SHALL wrap ram_addr to 0 and continue; ram_full is held at 0.
REQ-028 Macro AVG_RAM_CTRL_WRAP_EN undefined: CLEAR at the last address SHALL go to FULL, set ram_full=1, and hold there (no reads, no writes) until reset.

Verification
REQ-029 FIFO holds 10,20,30,40: fifo_rd high in cycles 0-3, reg_out in cycle 5, ram_wr_n=0 in cycle 6 at ram_addr=0, averager ram_data=25.
REQ-030 FIFO holds 255 x4 then 0,1,2,3: writes 255 @addr0 and 1 @addr1 (6>>2).
REQ-031 fifo_empty high for 3 cycles after the 2nd read: avg_data=0 and fifo_rd=0 during the gap, rd_cnt holds at 2; the group of 1,2,3,6 still writes 3.
REQ-032 reset_n pulsed low after 2 reads of 100: all outputs return to reset values; next group 4,4,4,4 writes 4 @addr0.
REQ-033 ADDR_W=2, 5 groups, macro defined: write addresses 0,1,2,3,0, ram_full=0 throughout.
REQ-034 ADDR_W=2, 5 groups, macro undefined: 4 writes, then ram_full=1; fifo_rd stays 0 with the 5th group still queued.
